// File: rtl/mips_mc_pkg.sv
// Shared multicycle-MIPS definitions: opcodes, memory access kinds, and the
// encoding of the memory access unit's states.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [1:0] {
    ACC_FETCH = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_STORE = 2'd2
  } acc_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts consecutive enabled cycles and flags the cycle in which the
// TIMEOUT_MAX-th one occurs.
module mem_watchdog #(
  parameter int TIMEOUT_MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_MAX > 1) ? $clog2(TIMEOUT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_MAX - 1);

  logic [CW-1:0] r_count;

  // Cycle counter, held at zero whenever the unit is not waiting on memory
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit for a multicycle MIPS: arbitrates fetch/load/store
// requests onto a single-outstanding request/ack memory bus.
module mem_access_unit
  import mips_mc_pkg::*;
#(
  parameter int TIMEOUT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic        rd_en,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_align
);

  mau_state_t r_state;
  mau_state_t w_next_state;
  acc_kind_t  r_kind;
  acc_kind_t  w_start_kind;
  acc_kind_t  w_kind_eff;

  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_instr;
  logic [31:0] r_mdr;
  logic        r_mem_req;
  logic        r_mem_we;
  logic        r_busy;
  logic        r_done;
  logic        r_err_timeout;
  logic        r_err_align;

  logic        w_start;
  logic [31:0] w_start_addr;
  logic        w_in_busy;
  logic        w_expire;
  logic        w_ack_hit;
  logic        w_timeout;
  logic        w_load_instr;
  logic        w_load_mdr;
  logic        w_req_next;
  logic        w_we_next;

  mem_watchdog #(
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start),
    .i_enable(w_in_busy),
    .o_expire(w_expire)
  );

  assign w_in_busy    = (r_state == ST_BUSY);
  assign w_start      = (r_state == ST_IDLE) && (MemWrite || IRWrite || rd_en);
  assign w_start_addr = IorD ? alu_out : pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; an ack arriving with the watchdog expiry still completes normally
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next_state = ST_BUSY;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack || w_expire) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_BUSY;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: next values for the registered bus/status outputs
  always_comb begin
    if (MemWrite) begin
      w_start_kind = ACC_STORE;
    end else if (IRWrite) begin
      w_start_kind = ACC_FETCH;
    end else begin
      w_start_kind = ACC_LOAD;
    end
    w_kind_eff   = w_start ? w_start_kind : r_kind;
    w_ack_hit    = w_in_busy && mem_ack;
    w_timeout    = w_in_busy && !mem_ack && w_expire;
    w_load_instr = w_ack_hit && (r_kind == ACC_FETCH);
    w_load_mdr   = w_ack_hit && (r_kind == ACC_LOAD);
    w_req_next   = (w_next_state == ST_BUSY);
    w_we_next    = w_req_next && (w_kind_eff == ACC_STORE);
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kind        <= ACC_FETCH;
      r_mem_addr    <= 32'h0000_0000;
      r_mem_wdata   <= 32'h0000_0000;
      r_instr       <= 32'h0000_0000;
      r_mdr         <= 32'h0000_0000;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_align   <= 1'b0;
    end else begin
      r_mem_req <= w_req_next;
      r_mem_we  <= w_we_next;
      r_busy    <= (w_next_state != ST_IDLE);
      r_done    <= (w_next_state == ST_DONE);
      if (w_start) begin
        r_kind      <= w_start_kind;
        r_mem_addr  <= word_align(w_start_addr);
        r_mem_wdata <= wdata;
      end else begin
        r_kind      <= r_kind;
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
      r_instr       <= w_load_instr ? mem_rdata : r_instr;
      r_mdr         <= w_load_mdr ? mem_rdata : r_mdr;
      r_err_timeout <= r_err_timeout || w_timeout;
      r_err_align   <= r_err_align || (w_start && is_misaligned(w_start_addr));
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign instr       = r_instr;
  assign op          = r_instr[31:26];
  assign mdr         = r_mdr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_timeout = r_err_timeout;
  assign err_align   = r_err_align;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_MAX, default 255, max BUSY cycles without mem_ack before abort.
REQ-002 SHALL have clk input 1: clock; reset, synchronous, active-high.
REQ-003 SHALL have reset input 1: synchronous active-high reset.
REQ-004 SHALL have IRWrite input 1: fetch request (read at pc into IR).
REQ-005 SHALL have rd_en input 1: data-load request (read into MDR).
REQ-006 SHALL have MemWrite input 1: store request.
REQ-007 SHALL have IorD input 1: address select, 0=pc, 1=alu_out.
REQ-008 SHALL have pc, alu_out, wdata inputs 32 each: fetch address, data address, store data.
REQ-009 SHALL have mem_req output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32: memory request bus.
REQ-010 SHALL have mem_ack input 1, mem_rdata input 32: one-cycle acknowledge with read data.
REQ-011 SHALL have instr output 32, op output 6 (instr[31:26]), mdr output 32: latched instruction, opcode to main decoder, memory data register.
REQ-012 SHALL have busy output 1, done output 1, err_timeout output 1, err_align output 1.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; only IDLE accepts requests.
REQ-014 Start in IDLE when any of MemWrite, IRWrite, rd_en high; priority MemWrite > IRWrite > rd_en; lower-priority requests dropped.
REQ-015 On start (cycle N), SHALL latch kind, address (IorD ? alu_out : pc), wdata; enter BUSY; mem_req=1 from N+1.
REQ-016 mem_addr SHALL carry latched address with bits [1:0] forced 00; nonzero low bits set err_align sticky, access still performed.
REQ-017 In BUSY, mem_req, mem_we (1 only for store), mem_addr, mem_wdata SHALL stay stable until ack or abort.
REQ-018 mem_ack in BUSY at cycle M: fetch -> instr<=mem_rdata; load -> mdr<=mem_rdata; store -> no register update; mem_req low from M+1; enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1 (cycle M+1, new instr/mdr visible), then IDLE; earliest next start M+2.
REQ-020 Minimum latency start->done SHALL be 2 cycles (ack at N+1).
REQ-021 busy SHALL equal 1 in BUSY and DONE, 0 in IDLE.
REQ-022 Watchdog SHALL count BUSY cycles from 0; when count reaches TIMEOUT_MAX without ack: mem_req low, err_timeout set sticky, instr/mdr unchanged, enter DONE (done pulses).
REQ-023 Ack in the same cycle as timeout SHALL win (normal completion, no error).
REQ-024 mem_ack in IDLE or DONE SHALL be ignored; requests in BUSY/DONE ignored.
REQ-025 op SHALL always equal instr[31:26] combinationally.

Reset
REQ-026 Reset SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr=0, mdr=0, done=0, busy=0, both error flags=0, watchdog=0.
REQ-027 Reset mid-BUSY SHALL abort immediately; a following mem_ack SHALL be ignored.
REQ-028 Error flags SHALL clear only by reset.

Structure
REQ-029 Shared package mips_mc_pkg SHALL hold opcode constants (LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000), access-kind enum (FETCH, LOAD, STORE), FSM state encoding.
REQ-030 Watchdog SHALL be sub-module mem_watchdog (clear, enable, TIMEOUT_MAX parameter, expire output).

Verification
REQ-031 Fetch: pc=0x00400000, IRWrite=1, ack at N+1 with 0x8C080004 -> mem_addr=0x00400000, instr=0x8C080004, op=100011, done at N+2.
REQ-032 Load: IorD=1, alu_out=0x10010008, rd_en=1, ack after 5 wait cycles with 0xDEADBEEF -> mdr=0xDEADBEEF, instr unchanged, mem_we=0 throughout.
REQ-033 Store+fetch same cycle: MemWrite=1, IRWrite=1, alu_out=0x10010010, wdata=0x12345678 -> single store, mem_we=1, mem_wdata=0x12345678, instr unchanged.
REQ-034 No ack: fetch with mem_ack held 0 -> mem_req drops after 255 BUSY cycles, err_timeout=1, done pulses once, instr unchanged.
REQ-035 Misaligned: alu_out=0x10010006 load -> mem_addr=0x10010004, err_align=1.
REQ-036 Reset on 3rd BUSY cycle, then ack -> all outputs at reset values, instr stays 0.
